morph_sched: RTL and testbench

- Per-frame scheduler and configurator for the two-stage binary morphology chain (stage 1 and stage 2, each a 3x3 erode/dilate/bypass unit) fed by the binarisation window generator.
- Accepts a mode request from the control side and applies it atomically at frame boundaries, so no frame is processed with mixed settings.
- Tracks pixel/line position from bin_vs/bin_de, produces window-border flags for edge padding, reports frame completion and geometry errors.

---
 rtl/morph_pkg.sv | 31 +++
 rtl/morph_pos_cnt.sv | 104 ++++++++++
 rtl/morph_sched.sv | 143 ++++++++++++++
 tb/tb_morph_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared definitions for the morphology chain scheduler.
// Holds the mode request encodings, the per-stage select encodings, the scheduler FSM
// state type, and the mode -> {stage1_sel, stage2_sel} mapping.
package morph_pkg;

  localparam logic [2:0] MODE_BYPASS = 3'd0;
  localparam logic [2:0] MODE_ERODE  = 3'd1;
  localparam logic [2:0] MODE_DILATE = 3'd2;
  localparam logic [2:0] MODE_OPEN   = 3'd3;
  localparam logic [2:0] MODE_CLOSE  = 3'd4;

  localparam logic [1:0] SEL_BYP = 2'b00;
  localparam logic [1:0] SEL_ERO = 2'b01;
  localparam logic [1:0] SEL_DIL = 2'b10;

  typedef enum logic [1:0] {StIdle, StArm, StActive, StDone} state_e;

  // Returns {stage1_sel, stage2_sel}; unused mode codes fall back to bypass.
  function automatic logic [3:0] mode_to_sel(input logic [2:0] mode);
    logic [3:0] sel;
    case (mode)
      MODE_ERODE:  sel = {SEL_ERO, SEL_BYP};
      MODE_DILATE: sel = {SEL_DIL, SEL_BYP};
      MODE_OPEN:   sel = {SEL_ERO, SEL_DIL};
      MODE_CLOSE:  sel = {SEL_DIL, SEL_ERO};
      default:     sel = {SEL_BYP, SEL_BYP};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/morph_pos_cnt.sv
// Pixel/line position tracker for the morphology window.
// Ports:
//   clk_i, rst_i        pixel clock, async active-high reset
//   vs_i, de_i          frame sync and active pixel enable
//   vs_rise_o           combinational frame-start strobe
//   de_fall_o           combinational end-of-line strobe
//   v_cnt_o             completed-line count in the current frame (saturating)
//   border_*_o, win_de_o  registered window-border flags, aligned with de delayed 1 clk
//   err_line_o          sticky line-length error, cleared at frame start
module morph_pos_cnt #(
  parameter int unsigned H_ACT = 1920,
  parameter int unsigned V_ACT = 1080,
  parameter int unsigned H_W   = 12,
  parameter int unsigned V_W   = 12
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           vs_i,
  input  logic           de_i,
  output logic           vs_rise_o,
  output logic           de_fall_o,
  output logic [V_W-1:0] v_cnt_o,
  output logic           border_l_o,
  output logic           border_r_o,
  output logic           border_t_o,
  output logic           border_b_o,
  output logic           win_de_o,
  output logic           err_line_o
);

  localparam logic [H_W-1:0] H_MAX  = {H_W{1'b1}};
  localparam logic [V_W-1:0] V_MAX  = {V_W{1'b1}};
  localparam logic [H_W-1:0] H_LEN  = H_W'(H_ACT);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_ACT - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_ACT - 1);

  logic           vs_q, de_q;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           err_line_q, err_line_d;
  logic           win_de_q, bl_q, br_q, bt_q, bb_q;
  logic           bl_d, br_d, bt_d, bb_d;

  assign vs_rise_o = vs_i & ~vs_q;
  assign de_fall_o = ~de_i & de_q;

  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    err_line_d = err_line_q;
    if (vs_rise_o) begin
      h_cnt_d    = '0;
      v_cnt_d    = '0;
      err_line_d = 1'b0;
    end else if (de_i) begin
      if (h_cnt_q != H_MAX) h_cnt_d = h_cnt_q + H_W'(1);
    end else if (de_fall_o) begin
      // h_cnt_q still holds the length of the line that just ended
      if (h_cnt_q != H_LEN) err_line_d = 1'b1;
      h_cnt_d = '0;
      if (v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + V_W'(1);
    end
    // Flags describe the pixel presented this clk, so they use pre-increment counts
    bl_d = de_i && (h_cnt_q == '0);
    br_d = de_i && (h_cnt_q == H_LAST);
    bt_d = de_i && (v_cnt_q == '0);
    bb_d = de_i && (v_cnt_q == V_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      err_line_q <= 1'b0;
      win_de_q   <= 1'b0;
      bl_q       <= 1'b0;
      br_q       <= 1'b0;
      bt_q       <= 1'b0;
      bb_q       <= 1'b0;
    end else begin
      vs_q       <= vs_i;
      de_q       <= de_i;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      err_line_q <= err_line_d;
      win_de_q   <= de_i;
      bl_q       <= bl_d;
      br_q       <= br_d;
      bt_q       <= bt_d;
      bb_q       <= bb_d;
    end
  end

  assign v_cnt_o    = v_cnt_q;
  assign border_l_o = bl_q;
  assign border_r_o = br_q;
  assign border_t_o = bt_q;
  assign border_b_o = bb_q;
  assign win_de_o   = win_de_q;
  assign err_line_o = err_line_q;

endmodule

// File: rtl/morph_sched.sv
// Per-frame scheduler/configurator for the two-stage 3x3 binary morphology chain.
// Mode requests are parked in a single pending slot and applied only at frame start,
// so a frame never sees mixed settings.
// Ports:
//   video_clk, rst              pixel clock, async active-high reset
//   cfg_mode/cfg_valid/cfg_ready  mode request handshake (one pending slot)
//   bin_vs, bin_de              frame sync and active pixel enable
//   stage1_sel, stage2_sel      registered per-stage select (00 byp, 01 erode, 10 dilate)
//   border_l/r/t/b, win_de      window-border flags for edge padding
//   frame_done, err_line, err_frame, busy  frame status
module morph_sched
  import morph_pkg::*;
#(
  parameter int unsigned H_ACT = 1920,
  parameter int unsigned V_ACT = 1080,
  parameter int unsigned H_W   = 12,
  parameter int unsigned V_W   = 12
) (
  input  logic       video_clk,
  input  logic       rst,
  input  logic [2:0] cfg_mode,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       bin_vs,
  input  logic       bin_de,
  output logic [1:0] stage1_sel,
  output logic [1:0] stage2_sel,
  output logic       border_l,
  output logic       border_r,
  output logic       border_t,
  output logic       border_b,
  output logic       win_de,
  output logic       frame_done,
  output logic       err_line,
  output logic       err_frame,
  output logic       busy
);

  localparam logic [V_W-1:0] V_LEN  = V_W'(V_ACT);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_ACT - 1);

  logic           vs_rise, de_fall;
  logic [V_W-1:0] v_cnt;

  state_e     state_q, state_d;
  logic [2:0] active_q, active_d;
  logic [2:0] pending_q, pending_d;
  logic       pending_vld_q, pending_vld_d;
  logic [3:0] sel_q, sel_d;
  logic       started_q, started_d;
  logic       frame_done_q, frame_done_d;
  logic       err_frame_q, err_frame_d;

  morph_pos_cnt #(
    .H_ACT(H_ACT),
    .V_ACT(V_ACT),
    .H_W  (H_W),
    .V_W  (V_W)
  ) u_pos_cnt (
    .clk_i     (video_clk),
    .rst_i     (rst),
    .vs_i      (bin_vs),
    .de_i      (bin_de),
    .vs_rise_o (vs_rise),
    .de_fall_o (de_fall),
    .v_cnt_o   (v_cnt),
    .border_l_o(border_l),
    .border_r_o(border_r),
    .border_t_o(border_t),
    .border_b_o(border_b),
    .win_de_o  (win_de),
    .err_line_o(err_line)
  );

  assign cfg_ready = ~pending_vld_q;

  always_comb begin
    active_d      = active_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    // Promotion frees the slot next clk; a same-clk request only lands when the slot
    // was already free, so the two never collide.
    if (vs_rise && pending_vld_q) begin
      active_d      = pending_q;
      pending_vld_d = 1'b0;
    end
    if (cfg_valid && cfg_ready) begin
      pending_d     = cfg_mode;
      pending_vld_d = 1'b1;
    end
    sel_d = mode_to_sel(active_q);
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    started_d    = started_q | vs_rise;
    err_frame_d  = vs_rise && started_q && (v_cnt != V_LEN);
    if (vs_rise) begin
      state_d = StArm;
    end else begin
      unique case (state_q)
        StArm:    if (bin_de) state_d = StActive;
        StActive: begin
          if (de_fall && (v_cnt == V_LAST)) begin
            state_d      = StDone;
            frame_done_d = 1'b1;
          end
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      active_q      <= MODE_BYPASS;
      pending_q     <= MODE_BYPASS;
      pending_vld_q <= 1'b0;
      sel_q         <= '0;
      started_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      sel_q         <= sel_d;
      started_q     <= started_d;
      frame_done_q  <= frame_done_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign stage1_sel = sel_q[3:2];
  assign stage2_sel = sel_q[1:0];
  assign frame_done = frame_done_q;
  assign err_frame  = err_frame_q;
  assign busy       = (state_q == StArm) || (state_q == StActive);

endmodule

// File: tb/tb_morph_sched.sv
module tb_morph_sched;

  localparam int H = 8;
  localparam int V = 4;

  logic       video_clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cfg_mode = 3'd0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       bin_vs = 1'b0;
  logic       bin_de = 1'b0;
  logic [1:0] stage1_sel, stage2_sel;
  logic       border_l, border_r, border_t, border_b, win_de;
  logic       frame_done, err_line, err_frame, busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (frame-level view of the scheduler)
  bit         m_started = 0;
  int         m_prev_lines = 0;
  logic [2:0] m_active = 3'd0;
  logic [2:0] m_pend = 3'd0;
  bit         m_pend_vld = 0;
  bit         m_err_line = 0;

  morph_sched #(
    .H_ACT(H),
    .V_ACT(V),
    .H_W  (4),
    .V_W  (4)
  ) dut (
    .video_clk (video_clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bin_vs    (bin_vs),
    .bin_de    (bin_de),
    .stage1_sel(stage1_sel),
    .stage2_sel(stage2_sel),
    .border_l  (border_l),
    .border_r  (border_r),
    .border_t  (border_t),
    .border_b  (border_b),
    .win_de    (win_de),
    .frame_done(frame_done),
    .err_line  (err_line),
    .err_frame (err_frame),
    .busy      (busy)
  );

  always #5 video_clk = ~video_clk;

  // Mode table: {stage1, stage2}
  function automatic logic [3:0] exp_sel(input logic [2:0] m);
    case (m)
      3'd1:    return 4'b01_00;
      3'd2:    return 4'b10_00;
      3'd3:    return 4'b01_10;
      3'd4:    return 4'b10_01;
      default: return 4'b00_00;
    endcase
  endfunction

  function automatic logic [13:0] all_outs();
    return {stage1_sel, stage2_sel, border_l, border_r, border_t, border_b, win_de,
            frame_done, err_line, err_frame, busy, cfg_ready};
  endfunction

  // One frame: vs pulse, nlines lines (line short_idx is H-1 long), optional request
  // on first pixel of line req_line and/or together with the vs rise.
  task automatic run_frame(input int nlines, input int short_idx, input int req_line,
                           input logic [2:0] req_mode, input bit req_at_vs);
    logic [3:0] old_sel;
    bit         exp_ef, ready_old;
    int         len;
    @(negedge video_clk);
    bin_vs    = 1'b1;
    cfg_valid = 1'b0;
    if (req_at_vs) begin
      cfg_valid = 1'b1;
      cfg_mode  = req_mode;
    end
    exp_ef    = m_started && (m_prev_lines != V);
    old_sel   = exp_sel(m_active);
    ready_old = !m_pend_vld;
    if (m_pend_vld) begin
      m_active   = m_pend;
      m_pend_vld = 0;
    end
    if (req_at_vs && ready_old) begin
      m_pend     = req_mode;
      m_pend_vld = 1;
    end
    m_started    = 1;
    m_err_line   = 0;
    m_prev_lines = 0;
    @(posedge video_clk); #1;
    n_vec++;
    if (err_frame !== exp_ef) begin
      n_err++; $display("FAIL err_frame@vs: got %b expected %b", err_frame, exp_ef);
    end
    n_vec++;
    if ({stage1_sel, stage2_sel} !== old_sel) begin
      n_err++;
      $display("FAIL sel@vs: got %b expected %b", {stage1_sel, stage2_sel}, old_sel);
    end
    n_vec++;
    if ({busy, err_line, frame_done} !== 3'b100) begin
      n_err++;
      $display("FAIL status@vs: got %b expected 100", {busy, err_line, frame_done});
    end
    n_vec++;
    if (cfg_ready !== !m_pend_vld) begin
      n_err++; $display("FAIL cfg_ready@vs: got %b expected %b", cfg_ready, !m_pend_vld);
    end
    @(negedge video_clk);
    bin_vs    = 1'b0;
    cfg_valid = 1'b0;
    @(posedge video_clk); #1;
    n_vec++;
    if ({err_frame, stage1_sel, stage2_sel} !== {1'b0, exp_sel(m_active)}) begin
      n_err++;
      $display("FAIL sel_after_vs: got %b expected %b", {err_frame, stage1_sel, stage2_sel},
               {1'b0, exp_sel(m_active)});
    end
    repeat ($urandom_range(1, 3)) @(negedge video_clk);
    for (int r = 0; r < nlines; r++) begin
      len = (r == short_idx) ? H - 1 : H;
      for (int c = 0; c < len; c++) begin
        if (c != 0 || r != 0) @(negedge video_clk);
        bin_de    = 1'b1;
        cfg_valid = 1'b0;
        if (r == req_line && c == 0) begin
          cfg_valid = 1'b1;
          cfg_mode  = req_mode;
          if (!m_pend_vld) begin
            m_pend     = req_mode;
            m_pend_vld = 1;
          end
        end
        @(posedge video_clk); #1;
        n_vec++;
        if ({win_de, border_l, border_r, border_t, border_b} !==
            {1'b1, c == 0, c == H - 1, r == 0, r == V - 1}) begin
          n_err++;
          $display("FAIL border r%0d c%0d: got %b expected %b", r, c,
                   {win_de, border_l, border_r, border_t, border_b},
                   {1'b1, c == 0, c == H - 1, r == 0, r == V - 1});
        end
        if (r == req_line && c == 0) begin
          n_vec++;
          if (cfg_ready !== !m_pend_vld) begin
            n_err++; $display("FAIL cfg_ready@req: got %b expected %b", cfg_ready, !m_pend_vld);
          end
        end
      end
      @(negedge video_clk);
      bin_de    = 1'b0;
      cfg_valid = 1'b0;
      if (len != H) m_err_line = 1;
      m_prev_lines++;
      @(posedge video_clk); #1;
      n_vec++;
      if ({err_line, frame_done, win_de, border_l, border_r, border_t, border_b,
           stage1_sel, stage2_sel} !== {m_err_line, r == V - 1, 5'b0, exp_sel(m_active)}) begin
        n_err++;
        $display("FAIL line_end r%0d: got %b expected %b", r,
                 {err_line, frame_done, win_de, border_l, border_r, border_t, border_b,
                  stage1_sel, stage2_sel}, {m_err_line, r == V - 1, 5'b0, exp_sel(m_active)});
      end
      @(posedge video_clk); #1;
      n_vec++;
      if (frame_done !== 1'b0) begin
        n_err++; $display("FAIL frame_done_pulse r%0d: got %b expected 0", r, frame_done);
      end
      repeat ($urandom_range(0, 2)) @(negedge video_clk);
    end
    repeat (2) @(negedge video_clk);
    n_vec++;
    if ({busy, err_line} !== {nlines < V, m_err_line}) begin
      n_err++;
      $display("FAIL frame_end: got %b expected %b", {busy, err_line}, {nlines < V, m_err_line});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge video_clk);
    n_vec++;
    if (all_outs() !== 14'b1) begin
      n_err++; $display("FAIL reset_outs: got %b expected %b", all_outs(), 14'b1);
    end
    rst = 1'b0;
    repeat (2) @(negedge video_clk);
    n_vec++;
    if (all_outs() !== 14'b1) begin
      n_err++; $display("FAIL post_reset_outs: got %b expected %b", all_outs(), 14'b1);
    end
  endtask

  task automatic test_basic_frame();
    run_frame(V, -1, -1, 3'd0, 0);
  endtask

  task automatic test_cfg_midframe();
    run_frame(V, -1, 1, 3'd3, 0);  // open requested mid-frame, sel stays bypass
    run_frame(V, -1, -1, 3'd0, 0); // open applied here
  endtask

  task automatic test_cfg_at_vs();
    run_frame(V, -1, -1, 3'd4, 1); // frame keeps open, close pending
  endtask

  task automatic test_errors();
    run_frame(V - 1, 1, -1, 3'd0, 0); // close applied; short line, short frame
    run_frame(V + 1, -1, -1, 3'd0, 0); // err_frame for prior; extra line, one frame_done
    run_frame(V, -1, -1, 3'd0, 0);     // err_frame for the 5-line frame
  endtask

  task automatic test_reset_mid();
    @(negedge video_clk);
    bin_vs = 1'b1;
    @(negedge video_clk);
    bin_vs = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 0) ? 5 : H); c++) begin
        @(negedge video_clk);
        bin_de    = 1'b1;
        cfg_valid = (r == 1 && c == 0);
        cfg_mode  = 3'd2;
        if (r == 2 && c == 3) break;
      end
      if (r == 2) break;
      @(negedge video_clk);
      bin_de    = 1'b0;
      cfg_valid = 1'b0;
    end
    @(posedge video_clk); #1;
    n_vec++;
    if ({err_line, busy, cfg_ready} !== 3'b110) begin
      n_err++; $display("FAIL pre_reset_state: got %b expected 110", {err_line, busy, cfg_ready});
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (all_outs() !== 14'b1) begin
      n_err++; $display("FAIL midframe_reset_outs: got %b expected %b", all_outs(), 14'b1);
    end
    @(negedge video_clk);
    bin_de    = 1'b0;
    cfg_valid = 1'b0;
    @(negedge video_clk);
    rst        = 1'b0;
    m_started  = 0;
    m_active   = 3'd0;
    m_pend_vld = 0;
    m_err_line = 0;
    run_frame(V, -1, -1, 3'd0, 0);
  endtask

  task automatic test_random();
    int nl, sh, rl;
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(V - 1, V + 1);
      sh = $urandom_range(0, 7);
      rl = $urandom_range(0, nl);
      run_frame(nl, (sh < nl) ? sh : -1, rl, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
    end
    run_frame(V, -1, -1, 3'd0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_cfg_midframe();
    test_cfg_at_vs();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
